// File: rtl/shield_scrubregfile.sv
// Byte-strobed register file with per-entry valid bits and a pointer-driven secure-erase scrub.
// Reset forces a full scrub because the data array itself is never reset.
module shield_scrubregfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_RD     = 2,
  parameter int RD_REG     = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]              rd_valid,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb,
  output logic                           wr_ready,
  input  logic                           clr_req,
  output logic                           clr_busy,
  output logic                           clr_done
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic {IDLE, SCRUB} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    clr_done_q, clr_done_d;
  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [DEPTH];
  logic                    wr_acc;

  assign wr_ready = (state_q == IDLE) && !clr_req;
  assign wr_acc   = wr_en && wr_ready;
  assign clr_busy = (state_q == SCRUB);
  assign clr_done = clr_done_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    clr_done_d = 1'b0;
    valid_d    = valid_q;
    mem_d      = mem_q;
    if (state_q == SCRUB) begin
      mem_d[ptr_q]   = '0;
      valid_d[ptr_q] = 1'b0;
      ptr_d          = ptr_q + 1'b1;
      if (ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
        state_d    = IDLE;
        clr_done_d = 1'b1;
      end
    end else if (clr_req) begin
      state_d = SCRUB;
      ptr_d   = '0;
    end else if (wr_acc && |wr_strb) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_strb[b]) mem_d[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
      end
      valid_d[wr_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= SCRUB;
      ptr_q      <= '0;
      clr_done_q <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      clr_done_q <= clr_done_d;
      valid_q    <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  generate
    if (RD_REG != 0) begin : g_rd_reg
      logic [NUM_RD*DATA_WIDTH-1:0] rd_data_q, rd_data_d;
      logic [NUM_RD-1:0]            rd_valid_q, rd_valid_d;

      // Sampling the next-state arrays gives write-first behaviour for writes and scrub alike.
      always_comb begin
        rd_data_d  = '0;
        rd_valid_d = '0;
        for (int k = 0; k < NUM_RD; k++) begin
          rd_valid_d[k] = valid_d[rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
          if (rd_valid_d[k])
            rd_data_d[k*DATA_WIDTH +: DATA_WIDTH] = mem_d[rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= '0;
        end else begin
          rd_data_q  <= rd_data_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end else begin : g_rd_comb
      always_comb begin
        rd_data  = '0;
        rd_valid = '0;
        for (int k = 0; k < NUM_RD; k++) begin
          rd_valid[k] = valid_q[rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
          if (rd_valid[k])
            rd_data[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_shield_scrubregfile.sv
// Bench for shield_scrubregfile: a combinational-read and a registered-read instance share stimulus;
// a reference model feeds expected read results into per-instance queues.
module tb_shield_scrubregfile;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int NR = 2;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR*AW-1:0] rd_addr;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [DW/8-1:0]  wr_strb;
  logic             clr_req;

  logic [NR*DW-1:0] rd_data0, rd_data1;
  logic [NR-1:0]    rd_valid0, rd_valid1;
  logic             wr_ready0, wr_ready1;
  logic             clr_busy0, clr_busy1;
  logic             clr_done0, clr_done1;

  shield_scrubregfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .RD_REG(0)) u_comb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .wr_ready(wr_ready0),
    .clr_req(clr_req), .clr_busy(clr_busy0), .clr_done(clr_done0));

  shield_scrubregfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .RD_REG(1)) u_reg (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .wr_ready(wr_ready1),
    .clr_req(clr_req), .clr_busy(clr_busy1), .clr_done(clr_done1));

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
  endtask

  logic [DW-1:0]    m_data [DEPTH];
  logic [DEPTH-1:0] m_valid;

  typedef struct packed {
    logic [NR-1:0]    v;
    logic [NR*DW-1:0] d;
  } rexp_t;

  rexp_t q0[$];
  rexp_t q1[$];

  function automatic rexp_t model_rd(input logic [NR*AW-1:0] ra);
    rexp_t e;
    logic [AW-1:0] a;
    e = '0;
    for (int k = 0; k < NR; k++) begin
      a = ra[k*AW +: AW];
      e.v[k] = m_valid[a];
      if (m_valid[a]) e.d[k*DW +: DW] = m_data[a];
    end
    return e;
  endfunction

  task automatic model_clear();
    m_valid = '0;
    for (int i = 0; i < DEPTH; i++) m_data[i] = '0;
  endtask

  // One bus cycle: drive, check combinational view before the edge, registered view after it.
  task automatic cyc(input string tag, input logic we, input logic [AW-1:0] wa,
                     input logic [DW-1:0] wd, input logic [DW/8-1:0] ws, input logic clr,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic exp_rdy);
    rexp_t e;
    wr_en = we; wr_addr = wa; wr_data = wd; wr_strb = ws; clr_req = clr;
    rd_addr = {a1, a0};
    q0.push_back(model_rd({a1, a0}));
    @(negedge clk);
    chk($sformatf("%s/rdy", tag), {63'd0, wr_ready0}, {63'd0, exp_rdy});
    e = q0.pop_front();
    chk($sformatf("%s/c_dat", tag), rd_data0, e.d);
    chk($sformatf("%s/c_vld", tag), {62'd0, rd_valid0}, {62'd0, e.v});
    if (we && exp_rdy && |ws) begin
      for (int b = 0; b < DW/8; b++) if (ws[b]) m_data[wa][8*b +: 8] = wd[8*b +: 8];
      m_valid[wa] = 1'b1;
    end
    q1.push_back(model_rd({a1, a0}));
    @(posedge clk); #1;
    e = q1.pop_front();
    chk($sformatf("%s/r_dat", tag), rd_data1, e.d);
    chk($sformatf("%s/r_vld", tag), {62'd0, rd_valid1}, {62'd0, e.v});
    wr_en = 1'b0; clr_req = 1'b0;
  endtask

  // Watch a scrub from its first cycle; optionally pulse clr_req or rst_n at a given scrub cycle.
  task automatic run_scrub(input string tag, input int clr_at, input int rst_at);
    int nb = 0;
    int nd = 0;
    int bad_rdy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rst_at >= 0 && i == rst_at + 1) begin
        rst_n = 1'b1;
        nb = 0;
      end
      if (clr_busy0) begin
        nb++;
        if (wr_ready0) bad_rdy++;
      end
      if (clr_done0) begin
        nd++;
        chk($sformatf("%s/done_busy", tag), {63'd0, clr_busy0}, 64'd0);
        chk($sformatf("%s/done_cvld", tag), {62'd0, rd_valid0}, 64'd0);
        chk($sformatf("%s/done_rvld", tag), {62'd0, rd_valid1}, 64'd0);
      end
      if (i == rst_at) rst_n = 1'b0;
      clr_req = (i == clr_at);
    end
    chk($sformatf("%s/busy_cycles", tag), 64'(nb), 64'd8);
    chk($sformatf("%s/done_pulses", tag), 64'(nd), 64'd1);
    chk($sformatf("%s/rdy_in_busy", tag), 64'(bad_rdy), 64'd0);
    clr_req = 1'b0;
    model_clear();
    @(posedge clk); #1;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < DEPTH; a += 2)
      cyc($sformatf("%s%0d", tag, a), 1'b0, '0, '0, '0, 1'b0, AW'(a), AW'(a + 1), 1'b1);
  endtask

  initial begin
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0; clr_req = 1'b0; rd_addr = '0;
    model_clear();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst/busy", {63'd0, clr_busy0}, 64'd1);
    chk("rst/rdy", {63'd0, wr_ready0}, 64'd0);
    chk("rst/done", {63'd0, clr_done0}, 64'd0);
    chk("rst/c_vld", {62'd0, rd_valid0}, 64'd0);
    chk("rst/r_vld", {62'd0, rd_valid1}, 64'd0);
    chk("rst/r_dat", rd_data1, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_scrub("init", -1, -1);
    read_all("init_rd");

    cyc("w_full", 1'b1, 3'd3, 32'hDEADBEEF, 4'hF, 1'b0, 3'd3, 3'd4, 1'b1);
    cyc("w_byte", 1'b1, 3'd3, 32'h0000AA00, 4'h2, 1'b0, 3'd3, 3'd4, 1'b1);
    cyc("rd3", 1'b0, '0, '0, '0, 1'b0, 3'd3, 3'd4, 1'b1);
    chk("rd3/lit", {32'd0, rd_data0[31:0]}, 64'h0000_0000_DEAD_AAEF);
    chk("rd4/lit_vld", {63'd0, rd_valid0[1]}, 64'd0);

    cyc("w_nostrb", 1'b1, 3'd4, 32'hFFFFFFFF, 4'h0, 1'b0, 3'd4, 3'd3, 1'b1);
    cyc("rd4", 1'b0, '0, '0, '0, 1'b0, 3'd4, 3'd4, 1'b1);

    cyc("bypass", 1'b1, 3'd5, 32'h12345678, 4'hF, 1'b0, 3'd5, 3'd5, 1'b1);
    chk("bypass/lit_dat", rd_data1, 64'h12345678_12345678);
    chk("bypass/lit_vld", {62'd0, rd_valid1}, 64'd3);

    cyc("w2", 1'b1, 3'd2, 32'hCAFEF00D, 4'hF, 1'b0, 3'd2, 3'd3, 1'b1);
    cyc("clr_wr", 1'b1, 3'd2, 32'h11111111, 4'hF, 1'b1, 3'd2, 3'd2, 1'b0);
    run_scrub("clr", -1, -1);
    read_all("clr_rd");

    cyc("w6", 1'b1, 3'd6, 32'hA5A5A5A5, 4'hF, 1'b0, 3'd6, 3'd6, 1'b1);
    cyc("clr2", 1'b0, '0, '0, '0, 1'b1, 3'd6, 3'd0, 1'b0);
    run_scrub("clr_ign", 4, -1);
    read_all("ign_rd");

    cyc("w7", 1'b1, 3'd7, 32'h0BADF00D, 4'hF, 1'b0, 3'd7, 3'd7, 1'b1);
    cyc("clr3", 1'b0, '0, '0, '0, 1'b1, 3'd7, 3'd0, 1'b0);
    run_scrub("rst_mid", -1, 4);
    read_all("rst_rd");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shield_scrubregfile.md
SHIELD_SCRUBREGFILE -- requirements
Module: shield_scrubregfile

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width; multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, address width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 SHALL have parameter NUM_RD, default 2, number of independent read ports.
REQ-004 SHALL have parameter RD_REG, default 0: 0 = combinational read, 1 = registered read.
REQ-005 SHALL have port clk, input, 1, clock; all state updates on posedge clk.
REQ-006 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have port rd_addr, input, NUM_RD*ADDR_WIDTH, packed read addresses; port k uses slice k.
REQ-008 SHALL have port rd_data, output, NUM_RD*DATA_WIDTH, packed read data.
REQ-009 SHALL have port rd_valid, output, NUM_RD, valid bit of each addressed entry.
REQ-010 SHALL have port wr_en, input, 1, write request.
REQ-011 SHALL have port wr_addr, input, ADDR_WIDTH, write address.
REQ-012 SHALL have port wr_data, input, DATA_WIDTH, write data.
REQ-013 SHALL have port wr_strb, input, DATA_WIDTH/8, byte enables; bit b covers wr_data[8b+7:8b].
REQ-014 SHALL have port wr_ready, output, 1, write accepted this cycle when wr_en is also high.
REQ-015 SHALL have port clr_req, input, 1, secure-erase request.
REQ-016 SHALL have port clr_busy, output, 1, scrub in progress.
REQ-017 SHALL have port clr_done, output, 1, one-cycle pulse when a scrub completes.

Function
REQ-018 SHALL hold DEPTH data words plus one valid bit per entry.
REQ-019 SHALL use FSM states IDLE and SCRUB, with a pointer ptr of ADDR_WIDTH bits.
REQ-020 SHALL drive wr_ready = (state==IDLE) && !clr_req, combinationally.
REQ-021 SHALL perform an accepted write (wr_en && wr_ready) by updating only the strobed bytes of wr_addr.
REQ-022 SHALL set the valid bit of wr_addr on an accepted write iff |wr_strb; a write with wr_strb==0 changes nothing.
REQ-023 SHALL drop writes presented with wr_ready low, with no side effects and no error indication.
REQ-024 SHALL, in IDLE with clr_req high, enter SCRUB with ptr=0 on the next cycle.
REQ-025 SHALL, in SCRUB, write zero to data[ptr], clear valid[ptr] and increment ptr each cycle; SCRUB lasts exactly DEPTH cycles.
REQ-026 SHALL leave SCRUB for IDLE after the ptr==DEPTH-1 cycle, and assert clr_done for exactly that following cycle.
REQ-027 SHALL drive clr_busy high iff state==SCRUB.
REQ-028 SHALL ignore clr_req while in SCRUB: no restart and no extra clr_done pulse.
REQ-029 SHALL drive rd_data lane k as 0 whenever the addressed entry is invalid, and as the stored word otherwise.
REQ-030 SHALL, with RD_REG=0, present read data combinationally from the current array; a same-cycle write becomes visible the following cycle.
REQ-031 SHALL, with RD_REG=1, register rd_data/rd_valid with one-cycle latency and write-first bypass: a same-cycle accepted write to the read address yields the byte-merged post-write value and valid=1.
REQ-032 SHALL allow reads during SCRUB and return the current partially scrubbed contents.
REQ-033 SHALL allow all read ports to address the same entry simultaneously.

Reset
REQ-034 SHALL, while rst_n is low, clear all valid bits, set state=SCRUB, ptr=0 and clr_done=0.
REQ-035 SHALL, with RD_REG=1, reset the registered rd_data and rd_valid to 0; with RD_REG=0 they are 0 by masking.
REQ-036 SHALL, after rst_n rises, complete a full DEPTH-cycle scrub (clr_busy=1, wr_ready=0) before accepting writes, because the data array itself is not reset.
REQ-037 SHALL abandon any in-progress scrub on reset and restart it from ptr=0.

Verification (DATA_WIDTH=32, ADDR_WIDTH=3, NUM_RD=2)
REQ-038 Reset release -> clr_busy=1 for 8 cycles, wr_ready=0 throughout, clr_done=1 for exactly one cycle with clr_busy=0, all rd_valid=0.
REQ-039 Write addr3 0xDEADBEEF strb 0xF, then 0x0000AA00 strb 0x2 -> read addr3 = 0xDEADAAEF, valid=1; addr4 = 0, valid=0.
REQ-040 RD_REG=1: read addr5 in the same cycle as a write of 0x12345678 strb 0xF to addr5 -> next cycle rd_data=0x12345678, rd_valid=1, on both ports.
REQ-041 clr_req and wr_en (addr2) in the same IDLE cycle -> write dropped; after clr_done every entry reads 0 with valid 0; busy lasts 8 cycles.
REQ-042 clr_req pulsed at SCRUB ptr=4 -> ignored: busy ends on schedule and exactly one clr_done pulse occurs.
REQ-043 rst_n low for one cycle at SCRUB ptr=4 -> scrub restarts at ptr=0 and runs a full 8 cycles.
